unified_cache_mem_responder: RTL and testbench
==============================================

# unified_cache_mem_responder

Memory-side responder for the unified cache's to-mem / from-mem packet interface. It accepts one miss or writeback packet at a time from the cache's to-mem port. It services the packet against an internal block-granular memory array after a fixed access latency, and returns a fill packet for reads on the cache's from-mem port. It stands in for main memory in the cache subsystem's integration and verification builds.

## Interface
Parameters:
- UNIFIED_CACHE_PACKET_WIDTH_IN_BITS, `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS: full packet width.
- BLOCK_SIZE, 64: block size in bytes; data field is BLOCK_SIZE*8 bits.
- NUM_BLOCK, 256: memory depth in blocks (power of two).
- ACCESS_LATENCY, 8: cycles from request ack to read-data valid; legal range 1..255.

Ports:
- clk_in  input  1  clock.
- reset_in  input  1  synchronous, active-high reset.
- request_packet_in  input  UNIFIED_CACHE_PACKET_WIDTH_IN_BITS  packet from the cache to-mem port; valid at `UNIFIED_CACHE_PACKET_VALID_POS.
- request_packet_ack_out  output  1  one-cycle accept pulse.
- return_packet_out  output  UNIFIED_CACHE_PACKET_WIDTH_IN_BITS  fill packet to the cache from-mem port; all zero when idle.
- return_packet_ack_in  input  1  cache accepted return_packet_out.

## Operation
- Packet fields use the shared header position macros: VALID, IS_WRITE, ADDR, DATA, PORT_NUM.
- Block index = ADDR[log2(BLOCK_SIZE) +: log2(NUM_BLOCK)]. Higher address bits are ignored, so addresses alias modulo NUM_BLOCK blocks.
- The FSM has three states: IDLE, ACCESS, RESPOND.
- IDLE:
  - A valid request sampled at an edge is latched in full.
  - ack_out goes 1 for exactly one cycle.
  - The counter loads ACCESS_LATENCY-1 and the state moves to ACCESS.
- ACCESS:
  - The counter decrements each edge.
  - At the edge where the counter is 0:
    - Write: DATA is written to the block and the state returns to IDLE. No return packet is produced.
    - Read: return_packet_out is loaded with the block data and the latched ADDR and PORT_NUM, with IS_WRITE=0 and VALID=1. The state moves to RESPOND.
- RESPOND:
  - return_packet_out is held stable.
  - When return_packet_ack_in is sampled 1, return_packet_out clears to zero at that edge and the state moves to IDLE.
- Requests presented outside IDLE are ignored and not acked. Upstream holds them until ack.
- The cycle in which ack_out=1 is never in IDLE, so a held request cannot be double-accepted.
- return_packet_ack_in is ignored unless in RESPOND.
- Memory contents are zero at time zero, are not cleared by reset, and persist across reset.
- Reset at any point:
  - The next state is IDLE.
  - ack_out=0 and return_packet_out=0.
  - Latched request and counter are cleared.
  - An in-flight write that has not reached its commit edge is dropped.

## Timing
- Reset values: request_packet_ack_out=0, return_packet_out=all zero, state IDLE.
- Request sampled valid at edge E0 in IDLE: ack_out is high in the cycle after E0 only.
- Read data is valid ACCESS_LATENCY cycles after the ack cycle begins.
- A write commits at edge E0+ACCESS_LATENCY. A read issued in the next cycle observes the new data.
- Throughput:
  - Write: one request per ACCESS_LATENCY+1 cycles.
  - Read: ACCESS_LATENCY+1 cycles plus return-ack wait.
- After a RESPOND→IDLE edge, a new request can be sampled at the very next edge.
- All outputs are registered. There are no combinational input-to-output paths.

## Structure
- Packet field positions and widths stay in parameters.h.
- Add `MEM_ACCESS_LATENCY as the shared default for ACCESS_LATENCY.
- Add the FSM state encodings as localparams in the module.
- One natural sub-module: single_port_ram.
  - NUM_BLOCK entries of BLOCK_SIZE*8 bits.
  - Synchronous write.
  - Synchronous read issued one cycle before the counter reaches 0. This cycle lies inside ACCESS when ACCESS_LATENCY ≥ 2.
  - When ACCESS_LATENCY=1, the read is issued from IDLE on the accept edge using the incoming address.

## Test plan
- Write then read: write ADDR=0x1C0, DATA=0xA5 pattern, then read ADDR=0x1C0 with PORT_NUM=1, ACCESS_LATENCY=8.
  - Each request gets one ack pulse.
  - Read return appears 8 cycles after its ack, with data=0xA5 pattern, PORT_NUM=1, IS_WRITE=0.
- Read of a never-written block after reset → return DATA=0, VALID=1.
- Aliasing: write ADDR=0x40, then read ADDR=0x40+NUM_BLOCK*BLOCK_SIZE → returns the written data.
- Backpressure: hold return_packet_ack_in=0 for 5 cycles while a second request is held valid.
  - return_packet_out stays stable.
  - The second request gets no ack until the cycle after the RESPOND→IDLE edge.
- Reset asserted in the middle of ACCESS of a write to ADDR=0x80.
  - Outputs are zero the next cycle.
  - A subsequent read of 0x80 returns the pre-write value.
- ACCESS_LATENCY=1 back-to-back reads with return_packet_ack_in tied 1 → each return appears 1 cycle after its ack, with data matching.

Source files
------------

// File: rtl/unified_cache_mem_responder_pkg.sv
// Shared packet layout, default memory latency and responder FSM states for the
// unified cache to-mem / from-mem interface.
package unified_cache_mem_responder_pkg;

  localparam int unsigned PKT_ADDR_W          = 32;
  localparam int unsigned PKT_DATA_W          = 512;
  localparam int unsigned PKT_PORT_W          = 2;

  localparam int unsigned PKT_VALID_POS       = 0;
  localparam int unsigned PKT_IS_WRITE_POS    = 1;
  localparam int unsigned PKT_ADDR_POS_LO     = 2;
  localparam int unsigned PKT_DATA_POS_LO     = PKT_ADDR_POS_LO + PKT_ADDR_W;
  localparam int unsigned PKT_PORT_NUM_POS_LO = PKT_DATA_POS_LO + PKT_DATA_W;
  localparam int unsigned PKT_WIDTH           = PKT_PORT_NUM_POS_LO + PKT_PORT_W;

  localparam int unsigned MEM_ACCESS_LATENCY  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESPOND
  } resp_state_e;

endpackage

// File: rtl/unified_cache_mem_responder_ram.sv
// Block-wide single-port RAM: synchronous write, registered synchronous read.
// Contents start at zero and have no reset, so they survive a system reset.
module unified_cache_mem_responder_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 512
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH] = '{default: '0};
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/unified_cache_mem_responder.sv
// Memory-side responder: accepts one miss/writeback packet at a time, services it
// against the block RAM after ACCESS_LATENCY cycles and returns fills for reads.
module unified_cache_mem_responder
  import unified_cache_mem_responder_pkg::*;
#(
  parameter int unsigned UNIFIED_CACHE_PACKET_WIDTH_IN_BITS = PKT_WIDTH,
  parameter int unsigned BLOCK_SIZE                         = 64,
  parameter int unsigned NUM_BLOCK                          = 256,
  parameter int unsigned ACCESS_LATENCY                     = MEM_ACCESS_LATENCY
) (
  input  logic                                          clk_in,
  input  logic                                          reset_in,
  input  logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] request_packet_in,
  output logic                                          request_packet_ack_out,
  output logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] return_packet_out,
  input  logic                                          return_packet_ack_in
);

  localparam int unsigned PW     = UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;
  localparam int unsigned OFF_W  = $clog2(BLOCK_SIZE);
  localparam int unsigned IDX_W  = $clog2(NUM_BLOCK);
  localparam int unsigned DATA_W = BLOCK_SIZE * 8;

  resp_state_e       state_q, state_d;
  logic [PW-1:0]     req_q, req_d;
  logic [PW-1:0]     ret_q, ret_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              ack_q, ack_d;

  logic              accept;
  logic              access_done;
  logic              req_is_write;
  logic              ram_we, ram_re;
  logic [IDX_W-1:0]  ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  assign accept       = (state_q == ST_IDLE) && request_packet_in[PKT_VALID_POS];
  assign access_done  = (state_q == ST_ACCESS) && (cnt_q == '0);
  assign req_is_write = req_q[PKT_IS_WRITE_POS];

  // RAM read is issued one edge before the counter expires so the data is ready
  // at the expiry edge; with a latency of 1 that edge is the accept edge itself.
  always_comb begin
    ram_re   = (state_q == ST_ACCESS) && (cnt_q == 8'd1);
    ram_addr = req_q[PKT_ADDR_POS_LO + OFF_W +: IDX_W];
    if (ACCESS_LATENCY == 1) begin
      ram_re = accept;
      if (state_q == ST_IDLE) ram_addr = request_packet_in[PKT_ADDR_POS_LO + OFF_W +: IDX_W];
    end
  end

  assign ram_we = access_done && req_is_write && req_q[PKT_VALID_POS] && !reset_in;

  unified_cache_mem_responder_ram #(
    .DEPTH (NUM_BLOCK),
    .WIDTH (DATA_W)
  ) u_ram (
    .clk_i   (clk_in),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (req_q[PKT_DATA_POS_LO +: DATA_W]),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      ret_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (accept) state_d = ST_ACCESS;
      ST_ACCESS:  if (cnt_q == '0) state_d = req_is_write ? ST_IDLE : ST_RESPOND;
      ST_RESPOND: if (return_packet_ack_in) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_d = req_q;
    ret_d = ret_q;
    cnt_d = cnt_q;
    ack_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_d = request_packet_in;
          cnt_d = 8'(ACCESS_LATENCY - 1);
          ack_d = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (!req_is_write) begin
          ret_d = '0;
          ret_d[PKT_VALID_POS] = 1'b1;
          ret_d[PKT_ADDR_POS_LO +: PKT_ADDR_W]     = req_q[PKT_ADDR_POS_LO +: PKT_ADDR_W];
          ret_d[PKT_DATA_POS_LO +: DATA_W]         = ram_rdata;
          ret_d[PKT_PORT_NUM_POS_LO +: PKT_PORT_W] = req_q[PKT_PORT_NUM_POS_LO +: PKT_PORT_W];
        end
      end
      ST_RESPOND: begin
        if (return_packet_ack_in) ret_d = '0;
      end
      default: ;
    endcase
  end

  assign request_packet_ack_out = ack_q;
  assign return_packet_out      = ret_q;

endmodule

// File: tb/tb_unified_cache_mem_responder.sv
// Randomized scoreboard bench for unified_cache_mem_responder: a latency-8 instance
// checked against a block-array reference model, plus a latency-1 instance.
module tb_unified_cache_mem_responder;
  import unified_cache_mem_responder_pkg::*;

  localparam int unsigned PW  = PKT_WIDTH;
  localparam int unsigned BS  = 64;
  localparam int unsigned NB  = 256;
  localparam int          LAT = 8;

  typedef logic [PW-1:0]  pkt_t;
  typedef logic [511:0]   data_t;
  typedef struct {
    pkt_t pkt;
    int   ack_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  pkt_t req_pkt, ret_pkt;
  logic req_ack, ret_ack;
  pkt_t req1, ret1;
  logic ack1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int free_edge = 0;
  int fixed_hold = -1;
  bit mon_busy = 1'b0;

  exp_t  exp_q[$];
  data_t model_mem[int];
  data_t model1_mem[int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  unified_cache_mem_responder #(
    .BLOCK_SIZE     (BS),
    .NUM_BLOCK      (NB),
    .ACCESS_LATENCY (LAT)
  ) u_dut (
    .clk_in                 (clk),
    .reset_in               (reset),
    .request_packet_in      (req_pkt),
    .request_packet_ack_out (req_ack),
    .return_packet_out      (ret_pkt),
    .return_packet_ack_in   (ret_ack)
  );

  unified_cache_mem_responder #(
    .BLOCK_SIZE     (BS),
    .NUM_BLOCK      (NB),
    .ACCESS_LATENCY (1)
  ) u_dut_l1 (
    .clk_in                 (clk),
    .reset_in               (reset),
    .request_packet_in      (req1),
    .request_packet_ack_out (ack1),
    .return_packet_out      (ret1),
    .return_packet_ack_in   (1'b1)
  );

  function automatic pkt_t make_pkt(input logic v, input logic wr, input logic [31:0] addr,
                                    input data_t data, input logic [1:0] port);
    pkt_t p;
    p = '0;
    p[PKT_VALID_POS]              = v;
    p[PKT_IS_WRITE_POS]           = wr;
    p[PKT_ADDR_POS_LO +: 32]      = addr;
    p[PKT_DATA_POS_LO +: 512]     = data;
    p[PKT_PORT_NUM_POS_LO +: 2]   = port;
    return p;
  endfunction

  function automatic int blk_of(input logic [31:0] addr);
    return int'((addr / BS) % NB);
  endfunction

  function automatic data_t rand_data();
    data_t d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic chk_pkt(input string name, input pkt_t act, input pkt_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Issues one request to the latency-8 instance starting at a falling edge.
  task automatic do_req(input logic wr, input logic [31:0] addr, input data_t data,
                        input logic [1:0] port, input bit commit);
    int p, c, n;
    data_t rd;
    p = cyc;
    req_pkt = make_pkt(1'b1, wr, addr, data, port);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ack && n < 400);
    if (!req_ack) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got=no ack want=ack within 400 cycles");
      req_pkt = '0;
      return;
    end
    c = cyc;
    chk_int("ack_timing", c, ((p > free_edge) ? p : free_edge) + 1);
    @(negedge clk);
    chk_int("ack_single_pulse", int'(req_ack), 0);
    req_pkt = '0;
    if (wr) begin
      if (commit) model_mem[blk_of(addr)] = data;
      free_edge = c + LAT;
    end else begin
      rd = model_mem.exists(blk_of(addr)) ? model_mem[blk_of(addr)] : '0;
      exp_q.push_back('{pkt: make_pkt(1'b1, 1'b0, addr, rd, port), ack_cyc: c});
    end
  endtask

  // Latency-1 instance: return must be visible one cycle after its ack.
  task automatic do_req1(input logic wr, input logic [31:0] addr, input data_t data,
                         input logic [1:0] port);
    int n;
    data_t rd;
    req1 = make_pkt(1'b1, wr, addr, data, port);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack1 && n < 50);
    if (!ack1) begin
      checks++;
      errors++;
      $display("FAIL l1_ack_timeout: got=no ack want=ack within 50 cycles");
      req1 = '0;
      return;
    end
    req1 = '0;
    if (wr) begin
      model1_mem[blk_of(addr)] = data;
      @(negedge clk);
      chk_pkt("l1_write_no_return", ret1, '0);
    end else begin
      rd = model1_mem.exists(blk_of(addr)) ? model1_mem[blk_of(addr)] : '0;
      @(negedge clk);
      chk_pkt("l1_return", ret1, make_pkt(1'b1, 1'b0, addr, rd, port));
    end
  endtask

  // Monitor / scoreboard for the latency-8 instance's return port.
  initial begin
    exp_t e;
    int   hold;
    ret_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (ret_pkt[PKT_VALID_POS]) begin
        mon_busy = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_return: got=%h want=no return", ret_pkt);
        end else begin
          e = exp_q.pop_front();
          chk_pkt("ret_data", ret_pkt, e.pkt);
          chk_int("ret_latency", cyc, e.ack_cyc + LAT);
          hold = (fixed_hold >= 0) ? fixed_hold : int'($urandom_range(0, 4));
          for (int j = 0; j < hold; j++) begin
            @(negedge clk);
            chk_pkt("ret_stable", ret_pkt, e.pkt);
          end
        end
        ret_ack = 1'b1;
        @(negedge clk);
        ret_ack = 1'b0;
        free_edge = cyc;
        chk_pkt("ret_clear", ret_pkt, '0);
        mon_busy = 1'b0;
      end else begin
        chk_pkt("idle_zero", ret_pkt, '0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    int n;
    reset   = 1'b1;
    req_pkt = '0;
    req1    = '0;
    repeat (3) @(negedge clk);
    chk_int("reset_ack", int'(req_ack), 0);
    chk_pkt("reset_ret", ret_pkt, '0);
    chk_int("reset_ack_l1", int'(ack1), 0);
    chk_pkt("reset_ret_l1", ret1, '0);
    reset = 1'b0;
    free_edge = cyc;

    // never-written block reads zero
    do_req(1'b0, 32'h0000_3000, '0, 2'd2, 1'b1);
    // write then read with port 1
    do_req(1'b1, 32'h0000_01C0, {64{8'hA5}}, 2'd0, 1'b1);
    do_req(1'b0, 32'h0000_01C0, '0, 2'd1, 1'b1);
    // aliasing across NUM_BLOCK blocks
    do_req(1'b1, 32'h0000_0040, rand_data(), 2'd3, 1'b1);
    do_req(1'b0, 32'h0000_0040 + NB * BS, '0, 2'd0, 1'b1);
    // backpressure: return held 5 cycles while the next request waits
    fixed_hold = 5;
    do_req(1'b0, 32'h0000_01C0, '0, 2'd2, 1'b1);
    do_req(1'b0, 32'h0000_0040, '0, 2'd1, 1'b1);
    fixed_hold = -1;

    // reset in the middle of a write's access phase drops the write
    do_req(1'b1, 32'h0000_0080, {16{32'h1234_5678}}, 2'd0, 1'b1);
    do_req(1'b1, 32'h0000_0080, {64{8'h3C}}, 2'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_int("mid_reset_ack", int'(req_ack), 0);
    chk_pkt("mid_reset_ret", ret_pkt, '0);
    free_edge = cyc;
    do_req(1'b0, 32'h0000_0080, '0, 2'd3, 1'b1);

    for (int i = 0; i < 40; i++) begin
      a = (32'($urandom_range(0, 7)) << 14) | (32'($urandom_range(0, 15)) << 6)
          | 32'($urandom_range(0, 63));
      do_req(1'($urandom_range(0, 1)), a, rand_data(), 2'($urandom_range(0, 3)), 1'b1);
    end

    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk_int("scoreboard_drained", exp_q.size() + int'(mon_busy), 0);

    // latency-1 instance: writes, then back-to-back reads incl. read right after write
    do_req1(1'b1, 32'h0000_0100, {64{8'h5A}}, 2'd0);
    do_req1(1'b1, 32'h0000_0240, rand_data(), 2'd1);
    do_req1(1'b0, 32'h0000_0240, '0, 2'd2);
    do_req1(1'b0, 32'h0000_0100 + NB * BS, '0, 2'd3);
    do_req1(1'b0, 32'h0000_0500, '0, 2'd1);
    for (int i = 0; i < 10; i++) begin
      a = (32'($urandom_range(0, 3)) << 14) | (32'($urandom_range(0, 7)) << 6);
      do_req1(1'($urandom_range(0, 1)), a, rand_data(), 2'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
